// File: rtl/pe_feeder.sv
// pe_feeder: sequences image/filter scratchpad reads into a PE MAC,
// issuing accumulator clear, MAC enables, result-slot stores and
// 4-result word writes for a run of num_out outputs.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   start               one-cycle run request (ignored while busy)
//   filt_len, num_out   MAC terms per output, outputs per run
//   stride, img_len     image base step per output, valid image bytes
//   img_wr_*, flt_wr_*  scratchpad load ports (accepted only when idle)
//   img_pixel,
//   filter_value        MAC operands (0 outside MAC)
//   rst_acc, acc_en,
//   res_buffer_en,
//   wr_en               PE controls
//   res_index, wr_adr   result slot / word address (0 when unused)
//   busy, done          run in progress, one-cycle completion pulse
//
// Build option: define PE_FEEDER_ZERO_PAD_EN to read image addresses
// at or beyond img_len as 0; otherwise addresses wrap mod IMG_DEPTH.

module pe_feeder #(
    parameter int IMG_DEPTH = 64,
    parameter int FLT_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] filt_len,
    input  logic [7:0] num_out,
    input  logic [7:0] stride,
    input  logic [7:0] img_len,
    input  logic       img_wr_en,
    input  logic [7:0] img_wr_adr,
    input  logic [7:0] img_wr_data,
    input  logic       flt_wr_en,
    input  logic [7:0] flt_wr_adr,
    input  logic [7:0] flt_wr_data,
    output logic [7:0] img_pixel,
    output logic [7:0] filter_value,
    output logic       rst_acc,
    output logic       acc_en,
    output logic       res_buffer_en,
    output logic       wr_en,
    output logic [7:0] res_index,
    output logic [7:0] wr_adr,
    output logic       busy,
    output logic       done
);

    localparam int IAW = (IMG_DEPTH > 1) ? $clog2(IMG_DEPTH) : 1;
    localparam int FAW = (FLT_DEPTH > 1) ? $clog2(FLT_DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_STORE,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] base_q, base_d;
    logic [7:0] k_q, k_d;
    logic [7:0] out_cnt_q, out_cnt_d;
    logic [7:0] word_cnt_q, word_cnt_d;
    logic [7:0] flen_q, flen_d;
    logic [7:0] nout_q, nout_d;
    logic [7:0] stride_q, stride_d;

    logic [7:0] img_mem [IMG_DEPTH];
    logic [7:0] flt_mem [FLT_DEPTH];

    logic       img_we, flt_we;
    logic [8:0] img_addr;
    logic [7:0] img_rd, flt_rd;
    logic [7:0] out_inc;

`ifdef PE_FEEDER_ZERO_PAD_EN
    logic [7:0] ilen_q, ilen_d;
`else
    logic       unused_img_len;
    assign unused_img_len = ^img_len;
`endif

    // Loads are only honoured between runs so a run sees stable data.
    assign img_we = img_wr_en && (state_q == S_IDLE) &&
                    ({1'b0, img_wr_adr} < 9'(IMG_DEPTH));
    assign flt_we = flt_wr_en && (state_q == S_IDLE) &&
                    ({1'b0, flt_wr_adr} < 9'(FLT_DEPTH));

    always_ff @(posedge clk) begin
        if (img_we) img_mem[IAW'(img_wr_adr)] <= img_wr_data;
        if (flt_we) flt_mem[FAW'(flt_wr_adr)] <= flt_wr_data;
    end

    // 9-bit sum so base+k never wraps before the pad/modulo decision.
    assign img_addr = {1'b0, base_q} + {1'b0, k_q};

    always_comb begin
        img_rd = img_mem[IAW'(img_addr % 9'(IMG_DEPTH))];
`ifdef PE_FEEDER_ZERO_PAD_EN
        if (img_addr >= {1'b0, ilen_q}) img_rd = '0;
`endif
    end

    assign flt_rd = ({1'b0, k_q} < 9'(FLT_DEPTH)) ?
                    flt_mem[FAW'(k_q)] : '0;

    assign out_inc = out_cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            k_q        <= '0;
            out_cnt_q  <= '0;
            word_cnt_q <= '0;
            flen_q     <= '0;
            nout_q     <= '0;
            stride_q   <= '0;
`ifdef PE_FEEDER_ZERO_PAD_EN
            ilen_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            k_q        <= k_d;
            out_cnt_q  <= out_cnt_d;
            word_cnt_q <= word_cnt_d;
            flen_q     <= flen_d;
            nout_q     <= nout_d;
            stride_q   <= stride_d;
`ifdef PE_FEEDER_ZERO_PAD_EN
            ilen_q     <= ilen_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        k_d           = k_q;
        out_cnt_d     = out_cnt_q;
        word_cnt_d    = word_cnt_q;
        flen_d        = flen_q;
        nout_d        = nout_q;
        stride_d      = stride_q;
`ifdef PE_FEEDER_ZERO_PAD_EN
        ilen_d        = ilen_q;
`endif
        img_pixel     = '0;
        filter_value  = '0;
        rst_acc       = 1'b0;
        acc_en        = 1'b0;
        res_buffer_en = 1'b0;
        wr_en         = 1'b0;
        res_index     = '0;
        wr_adr        = '0;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Run parameters are captured so mid-run input
                    // changes cannot disturb the sequence.
                    flen_d   = filt_len;
                    nout_d   = num_out;
                    stride_d = stride;
`ifdef PE_FEEDER_ZERO_PAD_EN
                    ilen_d   = img_len;
`endif
                    if (filt_len != 8'd0 && num_out != 8'd0) begin
                        state_d    = S_CLEAR;
                        base_d     = '0;
                        out_cnt_d  = '0;
                        word_cnt_d = '0;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_CLEAR: begin
                rst_acc = 1'b1;
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_en       = 1'b1;
                img_pixel    = img_rd;
                filter_value = flt_rd;
                if (k_q == flen_q - 8'd1) begin
                    state_d = S_STORE;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            S_STORE: begin
                res_buffer_en = 1'b1;
                res_index     = {6'd0, out_cnt_q[1:0]};
                out_cnt_d     = out_inc;
                base_d        = base_q + stride_q;
                // Flush a word on every 4th result or on the last one.
                if (out_inc[1:0] == 2'd0 || out_inc == nout_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_WRITE: begin
                wr_en      = 1'b1;
                wr_adr     = word_cnt_q;
                word_cnt_d = word_cnt_q + 8'd1;
                if (out_cnt_q == nout_q) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: randomized and directed checks of pe_feeder against a
// per-cycle expected-output queue built from the run rules.

module tb_pe_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] filt_len, num_out, stride, img_len;
    logic       img_wr_en, flt_wr_en;
    logic [7:0] img_wr_adr, img_wr_data, flt_wr_adr, flt_wr_data;
    logic [7:0] img_pixel, filter_value, res_index, wr_adr;
    logic       rst_acc, acc_en, res_buffer_en, wr_en, busy, done;

    always #5 clk = ~clk;

    pe_feeder dut (
        .clk(clk), .rst(rst), .start(start),
        .filt_len(filt_len), .num_out(num_out),
        .stride(stride), .img_len(img_len),
        .img_wr_en(img_wr_en), .img_wr_adr(img_wr_adr),
        .img_wr_data(img_wr_data),
        .flt_wr_en(flt_wr_en), .flt_wr_adr(flt_wr_adr),
        .flt_wr_data(flt_wr_data),
        .img_pixel(img_pixel), .filter_value(filter_value),
        .rst_acc(rst_acc), .acc_en(acc_en),
        .res_buffer_en(res_buffer_en), .wr_en(wr_en),
        .res_index(res_index), .wr_adr(wr_adr),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [7:0] pix;
        logic [7:0] fv;
        logic       ra;
        logic       ae;
        logic       rb;
        logic [7:0] ri;
        logic       we;
        logic [7:0] wa;
        logic       bz;
        logic       dn;
    } obs_t;

    obs_t act;
    always_comb act = {img_pixel, filter_value, rst_acc, acc_en,
                       res_buffer_en, res_index, wr_en, wr_adr,
                       busy, done};

    obs_t       exp_q[$];
    logic [7:0] img_m [64];
    logic [7:0] flt_m [16];
    int         pix_log[$], ri_log[$], wa_log[$], want[$];
    int         ra_n;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         done_cyc, wr_cyc, start_cyc;
    bit         chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, got, exp);
        end
    endtask

    task automatic ck_q(input string nm, input int got[$],
                        input int exp[$]);
        bit bad;
        bad = (got.size() != exp.size());
        for (int i = 0; i < got.size() && !bad; i++)
            if (got[i] != exp[i]) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got %p want %p", nm, got, exp);
        end
    endtask

    // Per-cycle compare; an empty queue means the DUT must be idle.
    always @(negedge clk) begin
        obs_t e;
        if (chk_en) begin
            e = '0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            chk("cycle", 64'(act), 64'(e));
            if (act.ae) pix_log.push_back(int'(act.pix));
            if (act.rb) ri_log.push_back(int'(act.ri));
            if (act.we) begin
                wa_log.push_back(int'(act.wa));
                wr_cyc = cyc;
            end
            if (act.ra) ra_n++;
            if (act.dn) done_cyc = cyc;
        end
    end

    function automatic logic [7:0] img_rd(input int a, input int il);
`ifdef PE_FEEDER_ZERO_PAD_EN
        if (a >= il) return 8'h00;
`endif
        return img_m[a % 64];
    endfunction

    // Expected output of every cycle of one run, from the run rules.
    task automatic model_run(input int fl, input int no,
                             input int st, input int il);
        obs_t e;
        int   base, word;
        if (fl == 0 || no == 0) begin
            e = '0; e.bz = 1; e.dn = 1;
            exp_q.push_back(e);
            return;
        end
        base = 0;
        word = 0;
        for (int o = 0; o < no; o++) begin
            e = '0; e.bz = 1; e.ra = 1;
            exp_q.push_back(e);
            for (int k = 0; k < fl; k++) begin
                e = '0; e.bz = 1; e.ae = 1;
                e.pix = img_rd(base + k, il);
                e.fv  = (k < 16) ? flt_m[k] : 8'h00;
                exp_q.push_back(e);
            end
            e = '0; e.bz = 1; e.rb = 1; e.ri = 8'(o % 4);
            exp_q.push_back(e);
            base = (base + st) % 256;
            if ((o + 1) % 4 == 0 || o + 1 == no) begin
                e = '0; e.bz = 1; e.we = 1; e.wa = 8'(word);
                word++;
                exp_q.push_back(e);
            end
        end
        e = '0; e.bz = 1; e.dn = 1;
        exp_q.push_back(e);
    endtask

    task automatic clr_logs();
        pix_log.delete(); ri_log.delete(); wa_log.delete();
        ra_n = 0; done_cyc = -100; wr_cyc = -100;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL timeout: busy=%0b left=%0d want idle",
                     busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic kick(input int fl, input int no,
                        input int st, input int il);
        clr_logs();
        filt_len = 8'(fl); num_out = 8'(no);
        stride = 8'(st); img_len = 8'(il);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        model_run(fl, no, st, il);
    endtask

    task automatic run(input int fl, input int no,
                       input int st, input int il);
        kick(fl, no, st, il);
        wait_idle();
    endtask

    task automatic wr_img(input int a, input int d);
        img_wr_en = 1'b1; img_wr_adr = 8'(a); img_wr_data = 8'(d);
        @(posedge clk); #1;
        img_wr_en = 1'b0;
        if (a < 64) img_m[a] = 8'(d);
    endtask

    task automatic wr_flt(input int a, input int d);
        flt_wr_en = 1'b1; flt_wr_adr = 8'(a); flt_wr_data = 8'(d);
        @(posedge clk); #1;
        flt_wr_en = 1'b0;
        if (a < 16) flt_m[a] = 8'(d);
    endtask

    initial begin
        int fl, no;
        rst = 1'b1; start = 1'b0;
        filt_len = '0; num_out = '0; stride = '0; img_len = '0;
        img_wr_en = 1'b0; img_wr_adr = '0; img_wr_data = '0;
        flt_wr_en = 1'b0; flt_wr_adr = '0; flt_wr_data = '0;
        clr_logs();
        #12;
        chk("reset_outputs", 64'(act), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 64; i++) wr_img(i, i + 1);
        for (int i = 0; i < 16; i++)
            wr_flt(i, (i < 3) ? 1 : int'($urandom_range(0, 255)));

        // Three-tap box filter, two outputs.
        run(3, 2, 1, 64);
        want = '{1, 2, 3, 2, 3, 4}; ck_q("r021_pix", pix_log, want);
        want = '{0, 1};             ck_q("r021_ri", ri_log, want);
        want = '{0};                ck_q("r021_wa", wa_log, want);
        chk("r021_done_lat", 64'(done_cyc - wr_cyc), 64'd1);

        // Five outputs spill into a second word.
        run(1, 5, 1, 64);
        want = '{0, 1, 2, 3, 0};    ck_q("r022_ri", ri_log, want);
        want = '{0, 1};             ck_q("r022_wa", wa_log, want);
        want = '{1, 2, 3, 4, 5};    ck_q("r022_pix", pix_log, want);

        // Degenerate runs go straight to done.
        run(0, 3, 1, 64);
        chk("r023_lat_ok", 64'(done_cyc - start_cyc <= 2), 64'd1);
        chk("r023_no_ra", 64'(ra_n), 64'd0);
        chk("r023_no_ae", 64'(pix_log.size()), 64'd0);
        chk("r023_no_we", 64'(wa_log.size()), 64'd0);
        run(3, 0, 1, 64);
        chk("r023b_no_ae", 64'(pix_log.size()), 64'd0);

        // Asynchronous reset in the middle of a MAC sequence.
        kick(5, 2, 1, 64);
        @(posedge clk); #1;
        chk("r024_in_mac", 64'(acc_en), 64'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("r024_zero", 64'(act), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        chk_en = 1'b1;
        clr_logs();
        repeat (4) @(posedge clk);
        #1;
        chk("r024_quiet", 64'(pix_log.size() + wa_log.size()), 64'd0);
        run(3, 2, 1, 64);
        want = '{1, 2, 3, 2, 3, 4}; ck_q("r024_rerun", pix_log, want);

        // Short image with stride 3.
        run(3, 2, 3, 4);
`ifdef PE_FEEDER_ZERO_PAD_EN
        want = '{1, 2, 3, 4, 0, 0};
`else
        want = '{1, 2, 3, 4, 5, 6};
`endif
        ck_q("r025_pix", pix_log, want);

        // Filter index past the filter scratchpad.
        run(18, 1, 0, 64);
        chk("r016_k16_fv", 64'(filter_value), 64'd0);

        // Start and loads while busy must be dropped.
        kick(4, 3, 2, 64);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        img_wr_en = 1'b1; img_wr_adr = 8'd0; img_wr_data = 8'hEE;
        flt_wr_en = 1'b1; flt_wr_adr = 8'd0; flt_wr_data = 8'hEE;
        @(posedge clk); #1;
        start = 1'b0; img_wr_en = 1'b0; flt_wr_en = 1'b0;
        wait_idle();
        run(1, 1, 0, 64);
        want = '{1}; ck_q("r026_img0", pix_log, want);

        // Out-of-range loads are dropped, not aliased.
        wr_img(70, 8'h5A);
        wr_flt(20, 8'h5A);
        run(8, 1, 0, 64);
        want = '{1, 2, 3, 4, 5, 6, 7, 8}; ck_q("r014_oor", pix_log, want);

        // Randomized runs with interleaved loads.
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 4))
                wr_img($urandom_range(0, 255), $urandom_range(0, 255));
            repeat ($urandom_range(0, 3))
                wr_flt($urandom_range(0, 31), $urandom_range(0, 255));
            fl = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 7);
            no = $urandom_range(0, 9);
            run(fl, no, $urandom_range(0, 255), $urandom_range(0, 80));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
